otp_scan_display: RTL and testbench

//  Parametrised, time-multiplexed two-channel 7-segment driver for the OTP compare path.

---
 rtl/otp_scan_display.sv | 110 +++++++++++
 tb/tb_otp_scan_display.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/otp_scan_display.sv
// otp_scan_display: two-channel time-multiplexed 7-segment driver showing snapshots of the user and LFSR OTP values.
module otp_scan_display #(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLINK_FRAMES = 64,
  parameter bit SEG_ACT_LOW  = 1'b0,
  parameter bit AN_ACT_LOW   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   user_otp,
  input  logic [4*DIGITS-1:0]   lfsr_otp,
  input  logic                  load,
  input  logic [1:0]            mode,
  input  logic                  blink,
  output logic [6:0]            seg1,
  output logic [6:0]            seg2,
  output logic [DIGITS-1:0]     an1,
  output logic [DIGITS-1:0]     an2
);
  localparam int W  = 4 * DIGITS;
  localparam int PW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  logic [PW-1:0]     pre;
  logic [IW-1:0]     idx;
  logic [FW-1:0]     fc;
  logic              phase;
  logic [W-1:0]      snap_u, snap_l;
  logic [1:0]        mode_r;
  logic              blink_r;
  logic [6:0]        s1, s2;
  logic [DIGITS-1:0] a1, a2;
  logic              pre_tc, idx_wrap, frame_tc, off1, off2;
  logic [3:0]        nib_u, nib_l;
  logic [DIGITS-1:0] sel;

  always_comb begin
    pre_tc   = pre == PW'(REFRESH_DIV - 1);
    idx_wrap = idx == IW'(DIGITS - 1);
    frame_tc = fc == FW'(BLINK_FRAMES - 1);
    off1     = mode_r[1] | (blink_r & phase);
    off2     = mode_r[0] | (blink_r & phase);
    nib_u    = 4'(snap_u >> {idx, 2'b00});
    nib_l    = 4'(snap_l >> {idx, 2'b00});
    sel      = DIGITS'(1) << idx;
  end

  // Outputs decode the state as it stood before this edge, giving the 1-cycle latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre     <= '0;
      idx     <= '0;
      fc      <= '0;
      phase   <= 1'b0;
      snap_u  <= '0;
      snap_l  <= '0;
      mode_r  <= '0;
      blink_r <= 1'b0;
      s1      <= '0;
      s2      <= '0;
      a1      <= '0;
      a2      <= '0;
    end else begin
      pre <= pre_tc ? '0 : pre + 1'b1;
      if (pre_tc) idx <= idx_wrap ? '0 : idx + 1'b1;
      if (pre_tc && idx_wrap) begin
        fc <= frame_tc ? '0 : fc + 1'b1;
        if (frame_tc) phase <= ~phase;
      end
      if (load) begin
        snap_u <= user_otp;
        snap_l <= lfsr_otp;
      end
      mode_r  <= mode;
      blink_r <= blink;
      s1      <= off1 ? '0 : hex7(nib_u);
      s2      <= off2 ? '0 : hex7(nib_l);
      a1      <= off1 ? '0 : sel;
      a2      <= off2 ? '0 : sel;
    end
  end

  assign seg1 = SEG_ACT_LOW ? ~s1 : s1;
  assign seg2 = SEG_ACT_LOW ? ~s2 : s2;
  assign an1  = AN_ACT_LOW ? ~a1 : a1;
  assign an2  = AN_ACT_LOW ? ~a2 : a2;
endmodule

// File: tb/tb_otp_scan_display.sv
// tb_otp_scan_display: directed checks of scan order, snapshots, mode blanking, blink, polarity and the single-digit corner.
module tb_otp_scan_display;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] user_otp = 16'h1234, lfsr_otp = 16'hABCD;
  logic load = 1'b1, blink = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [6:0] seg1, seg2, seg1a, seg2a;
  logic [3:0] an1, an2, an1a, an2a;

  logic [3:0] ub = 4'h7, lb = 4'h2;
  logic loadb = 1'b1;
  logic [6:0] segb1, segb2;
  logic [0:0] anb1, anb2;

  otp_scan_display #(.DIGITS(4), .REFRESH_DIV(4), .BLINK_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .user_otp(user_otp), .lfsr_otp(lfsr_otp), .load(load),
    .mode(mode), .blink(blink), .seg1(seg1), .seg2(seg2), .an1(an1), .an2(an2));

  otp_scan_display #(.DIGITS(4), .REFRESH_DIV(4), .BLINK_FRAMES(2), .SEG_ACT_LOW(1'b1), .AN_ACT_LOW(1'b1)) dut_al (
    .clk(clk), .rst(rst), .user_otp(user_otp), .lfsr_otp(lfsr_otp), .load(load),
    .mode(mode), .blink(blink), .seg1(seg1a), .seg2(seg2a), .an1(an1a), .an2(an2a));

  otp_scan_display #(.DIGITS(1), .REFRESH_DIV(1), .BLINK_FRAMES(2)) dut_b (
    .clk(clk), .rst(rst), .user_otp(ub), .lfsr_otp(lb), .load(loadb),
    .mode(2'b00), .blink(1'b0), .seg1(segb1), .seg2(segb2), .an1(anb1), .an2(anb2));

  int checks = 0, failures = 0, k = 0;
  logic [6:0] tu [4] = '{7'h66, 7'h4F, 7'h5B, 7'h06};
  logic [6:0] tl [4] = '{7'h5E, 7'h39, 7'h7C, 7'h77};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s k=%0d got=%h exp=%h", tag, k, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    k++;
  endtask

  // digit lit after edge k is ((k-1)/4)%4; uf selects the all-F user snapshot
  task automatic expect_scan(input string tag, input bit on1, input bit on2, input bit uf);
    int d;
    d = ((k - 1) / 4) % 4;
    chk({tag, ".an1"}, 32'(an1), on1 ? 32'(1 << d) : 32'd0);
    chk({tag, ".seg1"}, 32'(seg1), on1 ? (uf ? 32'h71 : 32'(tu[d])) : 32'd0);
    chk({tag, ".an2"}, 32'(an2), on2 ? 32'(1 << d) : 32'd0);
    chk({tag, ".seg2"}, 32'(seg2), on2 ? 32'(tl[d]) : 32'd0);
  endtask

  task automatic expect_off();
    chk("rst.seg1", 32'(seg1), 32'h0);
    chk("rst.seg2", 32'(seg2), 32'h0);
    chk("rst.an1", 32'(an1), 32'h0);
    chk("rst.an2", 32'(an2), 32'h0);
    chk("rst.al.seg1", 32'(seg1a), 32'h7F);
    chk("rst.al.seg2", 32'(seg2a), 32'h7F);
    chk("rst.al.an1", 32'(an1a), 32'hF);
    chk("rst.al.an2", 32'(an2a), 32'hF);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    expect_off();
    rst = 1'b0;
    tick();
    load = 1'b0;
    loadb = 1'b0;
    tick();
    expect_scan("scan", 1, 1, 0);
    chk("al.seg1", 32'(seg1a), 32'h19);
    chk("al.an1", 32'(an1a), 32'hE);
    while (k < 20) begin
      tick();
      expect_scan("scan", 1, 1, 0);
      chk("b.an1", 32'(anb1), 32'h1);
      chk("b.seg1", 32'(segb1), 32'h07);
      chk("b.seg2", 32'(segb2), 32'h5B);
    end
    user_otp = 16'hFFFF;
    while (k < 24) begin
      tick();
      expect_scan("hold", 1, 1, 0);
    end
    load = 1'b1;
    ub = 4'hE;
    loadb = 1'b1;
    tick();
    load = 1'b0;
    loadb = 1'b0;
    expect_scan("hold", 1, 1, 0);
    while (k < 33) begin
      tick();
      expect_scan("load", 1, 1, 1);
      chk("b.load", 32'(segb1), 32'h79);
    end
    mode = 2'b01;
    tick();
    expect_scan("mode01", 1, 1, 1);
    while (k < 38) begin
      tick();
      expect_scan("mode01", 1, 0, 1);
    end
    chk("al.blank.an2", 32'(an2a), 32'hF);
    chk("al.blank.seg2", 32'(seg2a), 32'h7F);
    mode = 2'b11;
    tick();
    expect_scan("mode11", 1, 0, 1);
    tick();
    expect_scan("mode11", 0, 0, 1);
    tick();
    expect_scan("mode11", 0, 0, 1);
    mode = 2'b00;
    tick();
    expect_scan("mode00", 0, 0, 1);
    tick();
    expect_scan("mode00", 1, 1, 1);
    blink = 1'b1;
    tick();
    expect_scan("blink", 1, 1, 1);
    while (k < 64) begin
      tick();
      expect_scan("blink.off", 0, 0, 1);
    end
    while (k < 96) begin
      tick();
      expect_scan("blink.on", 1, 1, 1);
    end
    while (k < 100) begin
      tick();
      expect_scan("blink.off", 0, 0, 1);
    end
    blink = 1'b0;
    tick();
    expect_scan("unblink", 0, 0, 1);
    tick();
    expect_scan("unblink", 1, 1, 1);
    #2 rst = 1'b1;
    #1 expect_off();
    @(negedge clk);
    expect_off();
    blink = 1'b1;
    rst = 1'b0;
    k = 0;
    while (k < 32) begin
      tick();
      chk("rst2.an1", 32'(an1), 32'(1 << (((k - 1) / 4) % 4)));
      chk("rst2.seg1", 32'(seg1), 32'h3F);
      chk("rst2.seg2", 32'(seg2), 32'h3F);
      chk("rst2.b.an1", 32'(anb1), 32'h1);
      chk("rst2.b.seg1", 32'(segb1), 32'h3F);
    end
    tick();
    chk("rst2.phase.an1", 32'(an1), 32'h0);
    chk("rst2.phase.seg2", 32'(seg2), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
